ifu_fetch_ctrl: RTL and testbench
=================================

# ifu_fetch_ctrl

Instruction-fetch sequencer for the rv64 core. It owns the architectural PC, issues single-outstanding fetch requests to instruction memory, and buffers one returned instruction for decode behind a valid/ready handshake. It also applies control-flow redirects from execute and, optionally, halts fetch on `ebreak`. It sits between the core top-level and the instruction memory port, replacing the free-running `ins`/`pc` pair with a handshaked front end.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC loaded on reset.
- `XLEN`, default 64: PC/address width.

- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset (driven from the synchronized reset).
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out XLEN: fetch address, always `pc`.
- `imem_rsp_valid` in 1: response valid, one cycle per accepted request.
- `imem_rsp_data` in 32: fetched instruction.
- `id_valid` out 1: instruction available to decode.
- `id_ready` in 1: decode consumes instruction.
- `id_ins` out 32: buffered instruction.
- `id_pc` out XLEN: PC of `id_ins`.
- `redirect_valid` in 1: redirect to a new PC (branch, jump, trap).
- `redirect_pc` in XLEN: redirect target; bits [1:0] are forced to 0.
- `halt` out 1: fetch stopped on `ebreak` (only with `IFU_HALT_EN`).

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD, HALT. At most one request is outstanding.
- **IDLE**: entered on reset. Goes to REQ on the next cycle unconditionally.
- **REQ**: `imem_req_valid`=1.
  - `imem_req_ready`=1 goes to WAIT.
  - `redirect_valid` without ready: `pc`←target, stay in REQ. The address may change while ready=0; memory must sample it only on the handshake.
  - Redirect together with ready: the old request is accepted, `pc`←target, go to DROP.
- **WAIT**:
  - `imem_rsp_valid` latches `id_ins`←data and `id_pc`←`pc`, then goes to HOLD.
  - Redirect without response: `pc`←target, go to DROP.
  - Redirect together with response: the response is discarded, `pc`←target, go to REQ.
- **DROP**: waits for `imem_rsp_valid`, discards it, then goes to REQ. A redirect here updates `pc` and stays in DROP.
- **HOLD**: `id_valid`=1.
  - Redirect has priority over `id_ready`. It discards the buffered instruction, sets `pc`←target, and goes to REQ; `id_valid` drops the next cycle.
  - `id_ready`=1 alone: `pc`←`pc`+4, wrapping modulo 2^XLEN, then go to REQ. Exception: with `IFU_HALT_EN` and `id_ins`==32'h0010_0073, `pc` is unchanged and the next state is HALT.
- **HALT**: `halt`=1. All outputs hold, redirects are ignored, and the block leaves HALT only on reset.
- A response that arrives in REQ, IDLE, HOLD or HALT is a protocol error. It is ignored; the bench asserts that it never occurs.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `id_valid`=0, `id_ins`=32'h0000_0013 (nop), `id_pc`=RESET_PC.
  - `halt`=0, state IDLE.
- `imem_req_valid` first rises in the 2nd cycle after `rst_n` goes high.
- Zero-wait memory (ready=1 in REQ, response the cycle after acceptance): REQ→WAIT→HOLD, so `id_valid` rises 2 cycles after `imem_req_valid`. With `id_ready`=1 throughput is 1 instruction per 3 cycles.
- A redirect takes effect on the next edge: `imem_req_addr` shows the target in the cycle after `redirect_valid`, in REQ or DROP.
- `id_ins`/`id_pc` are stable while `id_valid`=1 and `id_ready`=0.
- Asserting `rst_n`=0 mid-operation (any state) returns all outputs to their reset values on the next edge. Any in-flight response after reset arrives in IDLE or REQ and is ignored.
- All outputs are registered or decoded from the state register only; there are no combinational input→output paths.

## Configuration
- `IFU_HALT_EN` defined: `ebreak` (32'h0010_0073) consumed in HOLD moves to HALT, and `halt` goes high on the following cycle and stays high. The simulation top calls `$finish` on `halt`.
- Not defined: `ebreak` is delivered like any other instruction, the HALT state is not built, and `halt` is tied to 0.

## Test plan
- Reset release, zero-wait memory returning `32'h0000_0013`, `id_ready`=1: request addresses are 0x8000_0000, 0x8000_0004, 0x8000_0008, and `id_pc` tracks them 2 cycles later.
- Stall: `id_ready`=0 for 5 cycles in HOLD: `id_valid` stays 1, `id_ins`/`id_pc` are unchanged, no new request is issued, and `pc` advances by 4 only on the consuming cycle.
- Redirect to 0x8000_0102 in WAIT, response 3 cycles later: the response is dropped, `id_valid` never asserts for it, and the next request address is 0x8000_0100.
- Redirect and `id_ready` in the same HOLD cycle (target 0x8000_2000): the buffered instruction is discarded, `pc`=0x8000_2000, not 0x8000_0004.
- `pc`=0xFFFF_FFFF_FFFF_FFFC consumed: the next request address is 0x0.
- With `IFU_HALT_EN`, fetch 32'h0010_0073 and consume it: `halt`=1 the next cycle, `imem_req_valid` stays 0, and a redirect is ignored. Without the macro, the next request is at `pc`+4 and `halt` stays 0.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem request outstanding, buffers one instruction for decode (REQ->WAIT->HOLD, id_valid 2 cycles after request).
// Decode backpressure holds the buffer and stops new requests; IFU_HALT_EN makes a consumed ebreak park fetch in HALT until reset.
module ifu_fetch_ctrl #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_ins,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halt
);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
`ifdef IFU_HALT_EN
        ,
        HALT
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [31:0]     ins_buf;
    logic [31:0]     ins_buf_nxt;
    logic [XLEN-1:0] pc_buf;
    logic [XLEN-1:0] pc_buf_nxt;
    logic [XLEN-1:0] target;

    // Instructions are word aligned; low target bits are ignored.
    assign target = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ins_buf <= NOP;
            pc_buf  <= RESET_PC;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ins_buf <= ins_buf_nxt;
            pc_buf  <= pc_buf_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ins_buf_nxt = ins_buf;
        pc_buf_nxt  = pc_buf;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                end
                // A redirect coinciding with acceptance still owes memory one response.
                if (imem_req_ready) begin
                    state_nxt = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = target;
                    state_nxt = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    ins_buf_nxt = imem_rsp_data;
                    pc_buf_nxt  = pc;
                    state_nxt   = HOLD;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                end
                if (imem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (id_ready) begin
`ifdef IFU_HALT_EN
                    if (ins_buf == EBREAK) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = pc + XLEN'(4);
                        state_nxt = REQ;
                    end
`else
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = REQ;
`endif
                end
            end
`ifdef IFU_HALT_EN
            HALT: state_nxt = HALT;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign id_valid       = (state == HOLD);
    assign id_ins         = ins_buf;
    assign id_pc          = pc_buf;
`ifdef IFU_HALT_EN
    assign halt = (state == HALT);
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: random memory/decode/redirect traffic plus directed corner cases.
module tb_ifu_fetch_ctrl;

    localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] EBRK_ADDR = 64'h0000_0000_9000_0000;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ins;
    logic [63:0] id_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;

    ifu_fetch_ctrl #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_ins(id_ins), .id_pc(id_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int dly_min = 0;
    int dly_max = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] acc_q[$];
    logic [63:0] acc_log[$];
    int          acc_t[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Instruction memory image: a fixed hash of the address, with one ebreak.
    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        logic [31:0] h;
        if (a == EBRK_ADDR) return EBREAK;
        h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0013;
        if (h == EBREAK) h = NOP;
        return h;
    endfunction

    function automatic logic [63:0] rand_target();
        if ($urandom_range(7) == 0) return {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom_range(15))};
        return 64'h8000_0000 + 64'($urandom_range(65535));
    endfunction

    // Reference model: architectural PC, redirect epoch and the single pending fetch.
    logic [63:0] m_pc = RESET_PC;
    logic [63:0] m_paddr = 64'h0;
    logic        m_pend = 1'b0;
    logic        m_halt = 1'b0;
    logic        in_idle = 1'b1;
    int          epoch = 0;
    int          m_tag = 0;
    int          cnum = 0;

    always @(negedge clk) begin
        logic redir;
        exp_t e;
        cnum++;
        if (!rst_n) begin
            m_pc = RESET_PC;
            m_pend = 1'b0;
            m_halt = 1'b0;
            in_idle = 1'b1;
            exp_q.delete();
        end else begin
            chk("req_addr", imem_req_addr, m_pc);
            chk("halt", 64'(halt), 64'(m_halt));
            chk("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
            if (id_valid && exp_q.size() != 0) begin
                chk("id_pc", id_pc, exp_q[0].pc);
                chk("id_ins", 64'(id_ins), 64'(exp_q[0].ins));
            end
            if (in_idle) begin
                chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
                chk("rst_id_ins", 64'(id_ins), 64'(NOP));
                chk("rst_id_pc", id_pc, RESET_PC);
                in_idle = 1'b0;
            end else begin
                if (id_valid && imem_req_valid) begin
                    total++; bad++;
                    $display("FAIL req_while_hold: req_valid=1 id_valid=1 want not both");
                end
                if (m_halt && imem_req_valid) begin
                    total++; bad++;
                    $display("FAIL req_while_halt: req_valid=1 want 0");
                end
                redir = redirect_valid && !m_halt;
                if (imem_rsp_valid) begin
                    if (!m_pend) begin
                        total++; bad++;
                        $display("FAIL rsp_protocol: response with no outstanding request");
                    end else if (m_tag == epoch && !redir) begin
                        exp_q.push_back('{pc: m_paddr, ins: mem_fn(m_paddr)});
                    end
                    m_pend = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    acc_q.push_back(imem_req_addr);
                    acc_log.push_back(imem_req_addr);
                    acc_t.push_back(cnum);
                    m_pend = 1'b1;
                    m_tag = epoch;
                    m_paddr = m_pc;
                end
                if (redir) begin
                    m_pc = redirect_pc & ~64'd3;
                    epoch++;
                    exp_q.delete();
                end else if (id_valid && id_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
`ifdef IFU_HALT_EN
                    if (e.ins == EBREAK) m_halt = 1'b1;
                    else m_pc = m_pc + 64'd4;
`else
                    m_pc = m_pc + 64'd4;
`endif
                end
            end
        end
    end

    // Instruction memory: one response per accepted request after a random delay.
    logic [63:0] maddr = 64'h0;
    logic        mpend = 1'b0;
    int          mcnt = 0;

    always @(posedge clk) begin
        #2;
        imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            acc_q.delete();
            mpend = 1'b0;
        end else begin
            if (acc_q.size() != 0) begin
                maddr = acc_q.pop_front();
                mpend = 1'b1;
                mcnt = $urandom_range(dly_max, dly_min);
            end
            if (mpend) begin
                if (mcnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_fn(maddr);
                    mpend = 1'b0;
                end else begin
                    mcnt--;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idv();
        int n = 0;
        while (!id_valid && n < 60) begin cyc(); n++; end
        if (!id_valid) begin
            total++; bad++;
            $display("FAIL wait_id_valid: timeout after %0d cycles", n);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 60) begin cyc(); n++; end
        if (!imem_req_valid) begin
            total++; bad++;
            $display("FAIL wait_req_valid: timeout after %0d cycles", n);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        imem_req_ready = 1'b0;
        repeat (3) cyc();
        acc_log.delete();
        acc_t.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        cyc();
        reset_dut();

        // Zero-wait memory, decode always ready.
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        repeat (12) cyc();
        if (acc_log.size() < 3) begin
            total++; bad++;
            $display("FAIL zero_wait_count: got %0d requests want >=3", acc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk("zw_addr", acc_log[i], RESET_PC + 64'(4 * i));
                chk("zw_spacing", 64'(acc_t[i] - acc_t[0]), 64'(3 * i));
            end
        end

        // Decode stall in HOLD.
        id_ready = 1'b0;
        wait_idv();
        repeat (5) cyc();
        chk("stall_id_valid", 64'(id_valid), 64'd1);
        chk("stall_no_req", 64'(imem_req_valid), 64'd0);
        id_ready = 1'b1;
        cyc();

        // Redirect in WAIT, response three cycles later is dropped.
        dly_min = 3; dly_max = 3;
        wait_req();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0102;
        cyc();
        redirect_valid = 1'b0;
        wait_req();
        chk("wait_redirect_addr", imem_req_addr, 64'h8000_0100);

        // Redirect and id_ready together in HOLD.
        dly_min = 0; dly_max = 0;
        id_ready = 1'b0;
        wait_idv();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2000;
        id_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        chk("hold_redirect_vld", 64'(imem_req_valid), 64'd1);
        chk("hold_redirect_addr", imem_req_addr, 64'h8000_2000);

        // PC wrap-around.
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        wait_idv();
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        chk("wrap_addr", imem_req_addr, 64'h0);

        // Random traffic with a mid-operation reset.
        dly_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset_dut();
            end
            imem_req_ready = ($urandom_range(3) != 0);
            id_ready = ($urandom_range(2) != 0);
            redirect_valid = ($urandom_range(11) == 0);
            redirect_pc = rand_target();
            cyc();
        end

        // ebreak.
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) cyc();
        redirect_valid = 1'b1;
        redirect_pc = EBRK_ADDR;
        cyc();
        redirect_valid = 1'b0;
        wait_idv();
        chk("ebreak_ins", 64'(id_ins), 64'(EBREAK));
        chk("ebreak_pc", id_pc, EBRK_ADDR);
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
`ifdef IFU_HALT_EN
        chk("halt_set", 64'(halt), 64'd1);
        chk("halt_no_req", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0000;
        cyc();
        redirect_valid = 1'b0;
        repeat (3) cyc();
        chk("halt_stays", 64'(halt), 64'd1);
        chk("halt_no_req2", 64'(imem_req_valid), 64'd0);
        chk("halt_ignores_redirect", imem_req_addr, EBRK_ADDR);
`else
        wait_req();
        chk("ebreak_next_addr", imem_req_addr, EBRK_ADDR + 64'd4);
        chk("no_halt", 64'(halt), 64'd0);
`endif
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
